// File: rtl/level_judge_pkg.sv
// level_judge_pkg
// Shared types, default round constants and target/round-time helpers for
// the level judge. The helpers take the tuning values as arguments so a
// parameterised judge instance can reuse them with its own overrides.
package level_judge_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        PASS = 3'd3,
        FAIL = 3'd4
    } state_t;

    localparam int BASE_HITS_DEF    = 3;
    localparam int WORLD2_EXTRA_DEF = 2;
    localparam int TIME_BASE_DEF    = 60;
    localparam int TIME_STEP_DEF    = 5;
    localparam int TIME_MIN_DEF     = 20;
    localparam int LIVES_DEF        = 3;

    // Hits needed to clear a level; world 2 adds a fixed surcharge.
    function automatic logic [3:0] target_hits(
        input logic [2:0] level,
        input logic       world,
        input int         base_hits,
        input int         world2_extra
    );
        int total;
        total = base_hits + int'(level) + (world ? world2_extra : 0);
        return 4'(total);
    endfunction

    // Round time shrinks with level. The subtraction is done in 9-bit
    // two's complement so a large level*step goes negative (instead of
    // wrapping to a big positive value) and is then clamped to the floor.
    function automatic logic [7:0] round_time(
        input logic [2:0] level,
        input int         time_base,
        input int         time_step,
        input int         time_min
    );
        logic signed [8:0] t;
        logic signed [8:0] floor_t;
        t       = 9'(time_base) - 9'(level) * 9'(time_step);
        floor_t = 9'(time_min);
        if (t < floor_t)
            return 8'(time_min);
        return t[7:0];
    endfunction

endpackage

// File: rtl/level_judge_down_counter.sv
// judge_down_counter
// Loadable, enable-gated down-counter that sticks at zero.
// Ports:
//   clk, reset    clock, asynchronous active-high reset (count -> RST_VAL)
//   load          load load_val (takes priority over dec)
//   load_val      value to load
//   dec           decrement by one when count is nonzero
//   count         current value
//   zero          count == 0
module judge_down_counter #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= RST_VAL;
        else if (load)
            count <= load_val;
        else if (dec && (count != '0))
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/level_judge.sv
// level_judge
// Runs one timed round per start request and reports win/loss to the game FSM.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   level, world     current level/world, sampled when start is accepted
//   start            begin a round (honoured only when idle)
//   tick             timebase strobe
//   hit, miss        qualified player events
//   level_passed     1-cycle pulse, round won
//   level_failed     1-cycle pulse, round lost
//   busy             round loading or in play
//   hits_remaining   targets still needed
//   time_left        ticks remaining
//   lives_left       lives remaining
module level_judge
    import level_judge_pkg::*;
#(
    parameter int BASE_HITS    = BASE_HITS_DEF,
    parameter int WORLD2_EXTRA = WORLD2_EXTRA_DEF,
    parameter int TIME_BASE    = TIME_BASE_DEF,
    parameter int TIME_STEP    = TIME_STEP_DEF,
    parameter int TIME_MIN     = TIME_MIN_DEF,
    parameter int LIVES        = LIVES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] level,
    input  logic       world,
    input  logic       start,
    input  logic       tick,
    input  logic       hit,
    input  logic       miss,
    output logic       level_passed,
    output logic       level_failed,
    output logic       busy,
    output logic [3:0] hits_remaining,
    output logic [7:0] time_left,
    output logic [1:0] lives_left
);

    state_t     state;
    logic [2:0] level_q;
    logic       world_q;

    logic hits_zero, time_zero, lives_zero;
    logic in_play, load;
    logic hit_win, hits_dec, lives_dec, time_dec;
    logic lives_out, time_out;

    assign in_play = (state == PLAY);
    assign load    = (state == LOAD);

    // The winning hit pre-empts any miss or tick arriving in the same cycle,
    // so those counters are left untouched on that cycle.
    assign hit_win   = in_play && hit && (hits_remaining == 4'd1);
    assign hits_dec  = in_play && hit;
    assign lives_dec = in_play && miss && !hit_win;
    assign time_dec  = in_play && tick && !hit_win;
    assign lives_out = lives_dec && (lives_left == 2'd1);
    assign time_out  = time_dec && (time_left == 8'd1);

    judge_down_counter #(.W(4), .RST_VAL(4'd0)) u_hits (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (target_hits(level_q, world_q, BASE_HITS, WORLD2_EXTRA)),
        .dec      (hits_dec),
        .count    (hits_remaining),
        .zero     (hits_zero)
    );

    judge_down_counter #(.W(8), .RST_VAL(8'd0)) u_time (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (round_time(level_q, TIME_BASE, TIME_STEP, TIME_MIN)),
        .dec      (time_dec),
        .count    (time_left),
        .zero     (time_zero)
    );

    judge_down_counter #(.W(2), .RST_VAL(2'(LIVES))) u_lives (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (2'(LIVES)),
        .dec      (lives_dec),
        .count    (lives_left),
        .zero     (lives_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            level_q      <= '0;
            world_q      <= 1'b0;
            level_passed <= 1'b0;
            level_failed <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    level_passed <= 1'b0;
                    level_failed <= 1'b0;
                    if (start) begin
                        level_q <= level;
                        world_q <= world;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: state <= PLAY;
                PLAY: begin
                    // A counter already at zero in play (degenerate tuning)
                    // ends the round rather than stalling it.
                    if (hit_win || hits_zero) begin
                        level_passed <= 1'b1;
                        busy         <= 1'b0;
                        state        <= PASS;
                    end else if (lives_out || time_out || lives_zero || time_zero) begin
                        level_failed <= 1'b1;
                        busy         <= 1'b0;
                        state        <= FAIL;
                    end
                end
                PASS: begin
                    level_passed <= 1'b0;
                    state        <= IDLE;
                end
                FAIL: begin
                    level_failed <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    level_passed <= 1'b0;
                    level_failed <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_level_judge.sv
module tb_level_judge;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] level;
    logic       world;
    logic       start, start2;
    logic       tick, hit, miss;

    logic       passed, failed, busy;
    logic [3:0] hits;
    logic [7:0] tleft;
    logic [1:0] lives;

    logic       p2_passed, p2_failed, p2_busy;
    logic [3:0] p2_hits;
    logic [7:0] p2_tleft;
    logic [1:0] p2_lives;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       passed;
        logic       failed;
        logic [3:0] hits;
        logic [1:0] lives;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    level_judge dut (
        .clk(clk), .reset(reset), .level(level), .world(world),
        .start(start), .tick(tick), .hit(hit), .miss(miss),
        .level_passed(passed), .level_failed(failed), .busy(busy),
        .hits_remaining(hits), .time_left(tleft), .lives_left(lives)
    );

    level_judge #(.TIME_STEP(10)) dut_clamp (
        .clk(clk), .reset(reset), .level(level), .world(world),
        .start(start2), .tick(tick), .hit(hit), .miss(miss),
        .level_passed(p2_passed), .level_failed(p2_failed), .busy(p2_busy),
        .hits_remaining(p2_hits), .time_left(p2_tleft), .lives_left(p2_lives)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic p, input logic f, input logic [3:0] h, input logic [1:0] l);
        exp_t e;
        e.passed = p; e.failed = f; e.hits = h; e.lives = l;
        sb.push_back(e);
    endtask

    // Monitor: every end-of-round pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!reset && (passed || failed)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: passed=%0b failed=%0b with nothing expected", passed, failed);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_passed", int'(passed), int'(e.passed));
                chk("sb_failed", int'(failed), int'(e.failed));
                chk("sb_hits",   int'(hits),   int'(e.hits));
                chk("sb_lives",  int'(lives),  int'(e.lives));
            end
        end
    end

    task automatic begin_round(input logic [2:0] lv, input logic w);
        level = lv; world = w; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
    endtask

    initial begin
        reset = 1'b1; level = '0; world = 1'b0;
        start = 1'b0; start2 = 1'b0; tick = 1'b0; hit = 1'b0; miss = 1'b0;
        repeat (3) cyc();
        chk("rst_busy",   int'(busy),   0);
        chk("rst_hits",   int'(hits),   0);
        chk("rst_time",   int'(tleft),  0);
        chk("rst_lives",  int'(lives),  3);
        chk("rst_pulses", int'({passed, failed}), 0);
        reset = 1'b0;
        cyc();

        // Level 0 world 0: three spaced hits win the round.
        begin_round(3'd0, 1'b0);
        chk("l0_hits",  int'(hits),  3);
        chk("l0_time",  int'(tleft), 60);
        chk("l0_lives", int'(lives), 3);
        chk("l0_busy",  int'(busy),  1);
        for (int i = 0; i < 2; i++) begin
            hit = 1'b1; cyc(); hit = 1'b0;
            chk("l0_hits_dec", int'(hits), 2 - i);
            cyc();
        end
        push(1'b1, 1'b0, 4'd0, 2'd3);
        hit = 1'b1; cyc(); hit = 1'b0;
        chk("l0_pass_pulse", int'(passed), 1);
        chk("l0_busy_drop",  int'(busy),   0);
        cyc();
        chk("l0_pulse_end",  int'(passed), 0);

        // Level 7 world 1: 12 hits, 25 ticks; run the clock out.
        begin_round(3'd7, 1'b1);
        chk("l7_hits", int'(hits),  12);
        chk("l7_time", int'(tleft), 25);
        push(1'b0, 1'b1, 4'd12, 2'd3);
        tick = 1'b1;
        for (int i = 0; i < 25; i++) begin
            cyc();
            if (i == 9) chk("l7_time_mid", int'(tleft), 15);
        end
        tick = 1'b0;
        chk("l7_time_zero", int'(tleft),  0);
        chk("l7_failed",    int'(failed), 1);
        cyc();

        // Clamp: TIME_STEP=10 at level 7 would be -10; floor is 20.
        level = 3'd7; world = 1'b1; start2 = 1'b1;
        cyc();
        start2 = 1'b0;
        cyc();
        chk("clamp_time",   int'(p2_tleft), 20);
        chk("clamp_hits",   int'(p2_hits),  12);
        chk("clamp_lives",  int'(p2_lives), 3);
        chk("clamp_state",  int'({p2_busy, p2_passed, p2_failed}), 4);

        // Three misses lose the round; a later miss while idle does nothing.
        begin_round(3'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            miss = 1'b1; cyc(); miss = 1'b0;
            chk("miss_lives", int'(lives), 2 - i);
        end
        push(1'b0, 1'b1, 4'd3, 2'd0);
        miss = 1'b1; cyc(); miss = 1'b0;
        chk("miss_lives_zero", int'(lives), 0);
        chk("miss_failed", int'(failed), 1);
        cyc();
        miss = 1'b1; cyc(); miss = 1'b0;
        chk("idle_miss_lives", int'(lives), 0);
        chk("idle_miss_busy",  int'(busy),  0);

        // Hit+miss together applies both; final hit beats timeout and miss.
        begin_round(3'd0, 1'b0);
        hit = 1'b1; miss = 1'b1; cyc(); hit = 1'b0; miss = 1'b0;
        chk("hm_hits",  int'(hits),  2);
        chk("hm_lives", int'(lives), 2);
        hit = 1'b1; cyc(); hit = 1'b0;
        tick = 1'b1;
        repeat (59) cyc();
        tick = 1'b0;
        chk("race_time_one", int'(tleft), 1);
        chk("race_hits_one", int'(hits),  1);
        push(1'b1, 1'b0, 4'd0, 2'd2);
        hit = 1'b1; tick = 1'b1; miss = 1'b1;
        cyc();
        hit = 1'b0; tick = 1'b0; miss = 1'b0;
        chk("race_passed", int'(passed), 1);
        chk("race_failed", int'(failed), 0);
        cyc();

        // start in play is ignored; reset mid-round aborts silently.
        begin_round(3'd0, 1'b0);
        repeat (2) begin
            hit = 1'b1; cyc(); hit = 1'b0;
        end
        level = 3'd5; start = 1'b1; cyc(); start = 1'b0;
        cyc();
        chk("restart_hits", int'(hits), 1);
        chk("restart_busy", int'(busy), 1);
        #3 reset = 1'b1;
        #1;
        chk("abort_busy",   int'(busy),  0);
        chk("abort_hits",   int'(hits),  0);
        chk("abort_time",   int'(tleft), 0);
        chk("abort_lives",  int'(lives), 3);
        chk("abort_pulses", int'({passed, failed}), 0);
        #2 reset = 1'b0;
        repeat (4) cyc();
        chk("abort_idle", int'(busy), 0);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
